// File: rtl/pemstat_counters.sv
// Statistics counter bank: 44 event counters plus RX/TX byte counters with
// sticky wrap-carry flags, a masked interrupt and a small host register port.
module pemstat_counters #(
    parameter int CNT_W     = 18,
    parameter int BYTE_W    = 32,
    parameter int CLR_ON_RD = 0
) (
    input  logic        CORETSE_AHBo1Oi,
    input  logic        CORETSE_AHBi1Oi,
    input  logic [43:0] stat_inc_i,
    input  logic [15:0] stat_len_i,
    input  logic        clr_all_i,
    input  logic [5:0]  host_addr_i,
    input  logic        host_rd_i,
    input  logic        host_wr_i,
    input  logic [31:0] host_wdata_i,
    output logic [31:0] host_rdata_o,
    output logic        host_ack_o,
    output logic        stat_irq_o
);

    localparam int   NCNT = 44;
    localparam logic COR  = (CLR_ON_RD != 0);

    logic [CNT_W-1:0]  r_cnt [NCNT];
    logic [BYTE_W-1:0] r_rx_bytes;
    logic [BYTE_W-1:0] r_tx_bytes;
    logic [45:0]       r_carry;
    logic [45:0]       r_mask;
    logic [31:0]       r_rdata;
    logic              r_ack;
    logic              r_irq;

    logic [CNT_W-1:0]  w_cnt_nxt [NCNT];
    logic [43:0]       w_cnt_set;
    logic [1:0]        w_byte_set;
    logic [45:0]       w_carry_clr;
    logic [45:0]       w_carry_nxt;
    logic [45:0]       w_mask_nxt;
    logic [BYTE_W-1:0] w_rx_nxt;
    logic [BYTE_W-1:0] w_tx_nxt;
    logic [BYTE_W:0]   w_rx_sum;
    logic [BYTE_W:0]   w_tx_sum;
    logic [BYTE_W-1:0] w_len;
    logic [31:0]       w_rd_data;
    logic              w_wr;
    logic              w_rx_add;
    logic              w_tx_add;
    logic              w_cor_rx;
    logic              w_cor_tx;

    // A simultaneous read wins; the write is dropped.
    assign w_wr     = host_wr_i & ~host_rd_i;
    // When RX and TX frame bits coincide the length belongs to TX only.
    assign w_tx_add = stat_inc_i[24];
    assign w_rx_add = stat_inc_i[7] & ~stat_inc_i[24];
    assign w_len    = BYTE_W'(stat_len_i);
    assign w_rx_sum = {1'b0, r_rx_bytes} + {1'b0, w_len};
    assign w_tx_sum = {1'b0, r_tx_bytes} + {1'b0, w_len};
    assign w_cor_rx = COR & host_rd_i & (host_addr_i == 6'd44);
    assign w_cor_tx = COR & host_rd_i & (host_addr_i == 6'd45);

    // Host read mux over the pre-update register values.
    always_comb begin
        w_rd_data = 32'd0;
        if (host_addr_i < 6'd44) begin
            w_rd_data[CNT_W-1:0] = r_cnt[host_addr_i];
        end else begin
            case (host_addr_i)
                6'd44:   w_rd_data[BYTE_W-1:0] = r_rx_bytes;
                6'd45:   w_rd_data[BYTE_W-1:0] = r_tx_bytes;
                6'd46:   w_rd_data = r_carry[31:0];
                6'd47:   w_rd_data[13:0] = r_carry[45:32];
                6'd48:   w_rd_data = r_mask[31:0];
                6'd49:   w_rd_data[13:0] = r_mask[45:32];
                default: w_rd_data = 32'd0;
            endcase
        end
    end

    // Event counter next state; a clear-on-read keeps a same-cycle increment.
    always_comb begin
        w_cnt_set = 44'd0;
        for (int n = 0; n < NCNT; n++) begin
            w_cnt_nxt[n] = r_cnt[n];
            if (COR && host_rd_i && (host_addr_i == 6'(n))) begin
                w_cnt_nxt[n] = stat_inc_i[n] ? CNT_W'(1'b1) : {CNT_W{1'b0}};
            end else if (stat_inc_i[n]) begin
                w_cnt_nxt[n] = r_cnt[n] + CNT_W'(1'b1);
                w_cnt_set[n] = (r_cnt[n] == {CNT_W{1'b1}});
            end else begin
                w_cnt_nxt[n] = r_cnt[n];
            end
        end
    end

    // Byte counter next state and wrap detection.
    always_comb begin
        w_byte_set = 2'b00;
        w_rx_nxt   = r_rx_bytes;
        w_tx_nxt   = r_tx_bytes;
        if (w_cor_rx) begin
            w_rx_nxt = w_rx_add ? w_len : {BYTE_W{1'b0}};
        end else if (w_rx_add) begin
            w_rx_nxt      = w_rx_sum[BYTE_W-1:0];
            w_byte_set[0] = w_rx_sum[BYTE_W];
        end else begin
            w_rx_nxt = r_rx_bytes;
        end
        if (w_cor_tx) begin
            w_tx_nxt = w_tx_add ? w_len : {BYTE_W{1'b0}};
        end else if (w_tx_add) begin
            w_tx_nxt      = w_tx_sum[BYTE_W-1:0];
            w_byte_set[1] = w_tx_sum[BYTE_W];
        end else begin
            w_tx_nxt = r_tx_bytes;
        end
    end

    // Host writes: W1C on carries, mask load; new carry sets override the clear.
    always_comb begin
        w_carry_clr = 46'd0;
        w_mask_nxt  = r_mask;
        if (w_wr) begin
            case (host_addr_i)
                6'd46:   w_carry_clr[31:0]  = host_wdata_i;
                6'd47:   w_carry_clr[45:32] = host_wdata_i[13:0];
                6'd48:   w_mask_nxt[31:0]   = host_wdata_i;
                6'd49:   w_mask_nxt[45:32]  = host_wdata_i[13:0];
                default: w_carry_clr = 46'd0;
            endcase
        end else begin
            w_carry_clr = 46'd0;
        end
        w_carry_nxt = (r_carry & ~w_carry_clr) | {w_byte_set, w_cnt_set};
    end

    // State registers; clr_all_i dominates every counter/carry update.
    always_ff @(posedge CORETSE_AHBo1Oi) begin
        if (CORETSE_AHBi1Oi) begin
            for (int n = 0; n < NCNT; n++) begin
                r_cnt[n] <= {CNT_W{1'b0}};
            end
            r_rx_bytes <= {BYTE_W{1'b0}};
            r_tx_bytes <= {BYTE_W{1'b0}};
            r_carry    <= 46'd0;
            r_mask     <= {46{1'b1}};
            r_rdata    <= 32'd0;
            r_ack      <= 1'b0;
            r_irq      <= 1'b0;
        end else begin
            r_ack <= host_rd_i | host_wr_i;
            if (host_rd_i) begin
                r_rdata <= w_rd_data;
            end
            r_irq  <= |(r_carry & ~r_mask);
            r_mask <= w_mask_nxt;
            if (clr_all_i) begin
                for (int n = 0; n < NCNT; n++) begin
                    r_cnt[n] <= {CNT_W{1'b0}};
                end
                r_rx_bytes <= {BYTE_W{1'b0}};
                r_tx_bytes <= {BYTE_W{1'b0}};
                r_carry    <= 46'd0;
            end else begin
                for (int n = 0; n < NCNT; n++) begin
                    r_cnt[n] <= w_cnt_nxt[n];
                end
                r_rx_bytes <= w_rx_nxt;
                r_tx_bytes <= w_tx_nxt;
                r_carry    <= w_carry_nxt;
            end
        end
    end

    assign host_rdata_o = r_rdata;
    assign host_ack_o   = r_ack;
    assign stat_irq_o   = r_irq;

endmodule

// File: tb/tb_pemstat_counters.sv
// Bench for pemstat_counters: two instances (plain and clear-on-read) share
// stimulus and are compared every cycle against an arithmetic reference model.
module tb_pemstat_counters;

    localparam int CW   = 8;
    localparam int BW   = 16;
    localparam int CMOD = 1 << CW;
    localparam longint BMOD = 64'd1 << BW;

    logic        clk = 1'b0;
    logic        rst;
    logic [43:0] inc;
    logic [15:0] len;
    logic        clr;
    logic [5:0]  addr;
    logic        rd;
    logic        wr;
    logic [31:0] wdata;
    logic [31:0] rdata0, rdata1;
    logic        ack0, ack1, irq0, irq1;

    int          m_cnt [2][44];
    longint      m_rx [2];
    longint      m_tx [2];
    logic [45:0] m_carry [2];
    logic [45:0] m_mask [2];
    logic [31:0] e_rdata [2];
    logic        e_ack;
    logic        e_irq [2];
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;

    pemstat_counters #(.CNT_W(CW), .BYTE_W(BW), .CLR_ON_RD(0)) u_dut (
        .CORETSE_AHBo1Oi(clk), .CORETSE_AHBi1Oi(rst), .stat_inc_i(inc), .stat_len_i(len),
        .clr_all_i(clr), .host_addr_i(addr), .host_rd_i(rd), .host_wr_i(wr),
        .host_wdata_i(wdata), .host_rdata_o(rdata0), .host_ack_o(ack0), .stat_irq_o(irq0));

    pemstat_counters #(.CNT_W(CW), .BYTE_W(BW), .CLR_ON_RD(1)) u_dut_cor (
        .CORETSE_AHBo1Oi(clk), .CORETSE_AHBi1Oi(rst), .stat_inc_i(inc), .stat_len_i(len),
        .clr_all_i(clr), .host_addr_i(addr), .host_rd_i(rd), .host_wr_i(wr),
        .host_wdata_i(wdata), .host_rdata_o(rdata1), .host_ack_o(ack1), .stat_irq_o(irq1));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] m_read(input int k, input logic [5:0] a);
        if (a < 6'd44) return 32'(m_cnt[k][a]);
        case (a)
            6'd44:   return 32'(m_rx[k]);
            6'd45:   return 32'(m_tx[k]);
            6'd46:   return m_carry[k][31:0];
            6'd47:   return {18'd0, m_carry[k][45:32]};
            6'd48:   return m_mask[k][31:0];
            6'd49:   return {18'd0, m_mask[k][45:32]};
            default: return 32'd0;
        endcase
    endfunction

    // Reference behaviour for one clock edge, applied to both instances.
    task automatic model_step();
        logic [45:0] setb, clrb;
        bit cor;
        longint sum;
        e_ack = rst ? 1'b0 : (rd | wr);
        for (int k = 0; k < 2; k++) begin
            cor = (k == 1);
            if (rst) begin
                for (int n = 0; n < 44; n++) m_cnt[k][n] = 0;
                m_rx[k] = 0; m_tx[k] = 0;
                m_carry[k] = '0; m_mask[k] = '1;
                e_rdata[k] = 32'd0; e_irq[k] = 1'b0;
                continue;
            end
            e_irq[k] = |(m_carry[k] & ~m_mask[k]);
            if (rd) e_rdata[k] = m_read(k, addr);
            setb = '0; clrb = '0;
            for (int n = 0; n < 44; n++) begin
                if (cor && rd && addr == 6'(n)) m_cnt[k][n] = inc[n] ? 1 : 0;
                else if (inc[n]) begin
                    if (m_cnt[k][n] + 1 >= CMOD) setb[n] = 1'b1;
                    m_cnt[k][n] = (m_cnt[k][n] + 1) % CMOD;
                end
            end
            if (inc[24]) begin
                if (cor && rd && addr == 6'd45) m_tx[k] = len;
                else begin
                    sum = m_tx[k] + len;
                    if (sum >= BMOD) setb[45] = 1'b1;
                    m_tx[k] = sum % BMOD;
                end
            end else if (cor && rd && addr == 6'd45) m_tx[k] = 0;
            if (inc[7] && !inc[24]) begin
                if (cor && rd && addr == 6'd44) m_rx[k] = len;
                else begin
                    sum = m_rx[k] + len;
                    if (sum >= BMOD) setb[44] = 1'b1;
                    m_rx[k] = sum % BMOD;
                end
            end else if (cor && rd && addr == 6'd44) m_rx[k] = 0;
            if (wr && !rd) begin
                if (addr == 6'd46) clrb[31:0] = wdata;
                if (addr == 6'd47) clrb[45:32] = wdata[13:0];
                if (addr == 6'd48) m_mask[k][31:0] = wdata;
                if (addr == 6'd49) m_mask[k][45:32] = wdata[13:0];
            end
            m_carry[k] = (m_carry[k] & ~clrb) | setb;
            if (clr) begin
                for (int n = 0; n < 44; n++) m_cnt[k][n] = 0;
                m_rx[k] = 0; m_tx[k] = 0; m_carry[k] = '0;
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        chk("ack0", 32'(ack0), 32'(e_ack));
        chk("ack1", 32'(ack1), 32'(e_ack));
        chk("rdata0", rdata0, e_rdata[0]);
        chk("rdata1", rdata1, e_rdata[1]);
        chk("irq0", 32'(irq0), 32'(e_irq[0]));
        chk("irq1", 32'(irq1), 32'(e_irq[1]));
    endtask

    task automatic idle();
        inc = 44'd0; len = 16'd0; clr = 1'b0; rd = 1'b0; wr = 1'b0; addr = 6'd0; wdata = 32'd0;
    endtask

    task automatic cyc(input logic [43:0] i, input logic [15:0] l, input logic c,
                       input logic r, input logic w, input logic [5:0] a, input logic [31:0] d);
        inc = i; len = l; clr = c; rd = r; wr = w; addr = a; wdata = d;
        tick();
        idle();
    endtask

    task automatic rd_reg(input logic [5:0] a);
        cyc(44'd0, 16'd0, 1'b0, 1'b1, 1'b0, a, 32'd0);
    endtask

    task automatic wr_reg(input logic [5:0] a, input logic [31:0] d);
        cyc(44'd0, 16'd0, 1'b0, 1'b0, 1'b1, a, d);
    endtask

    task automatic clear_all();
        cyc(44'd0, 16'd0, 1'b1, 1'b0, 1'b0, 6'd0, 32'd0);
    endtask

    initial begin
        logic [43:0] b7, b24, b3, b10, ri;
        b7 = 44'd1 << 7; b24 = 44'd1 << 24; b3 = 44'd1 << 3; b10 = 44'd1 << 10;
        idle();
        rst = 1'b1;
        tick(); tick();
        rst = 1'b0;

        rd_reg(6'd5);
        chk("t1_ack", 32'(ack0), 32'd1);
        chk("t1_rdata", rdata0, 32'd0);
        tick();
        chk("t1_ack_drop", 32'(ack0), 32'd0);

        cyc(b7, 16'd64, 1'b0, 1'b0, 1'b0, 6'd0, 32'd0);
        cyc(b7, 16'd1518, 1'b0, 1'b0, 1'b0, 6'd0, 32'd0);
        cyc(b7, 16'd100, 1'b0, 1'b0, 1'b0, 6'd0, 32'd0);
        rd_reg(6'd7);  chk("t2_cnt7", rdata0, 32'd3);
        rd_reg(6'd44); chk("t2_rx", rdata0, 32'd1682);
        rd_reg(6'd45); chk("t2_tx", rdata0, 32'd0);

        clear_all();
        cyc(b7 | b24, 16'd200, 1'b0, 1'b0, 1'b0, 6'd0, 32'd0);
        rd_reg(6'd7);  chk("t3_cnt7", rdata0, 32'd1);
        rd_reg(6'd24); chk("t3_cnt24", rdata0, 32'd1);
        rd_reg(6'd45); chk("t3_tx", rdata0, 32'd200);
        rd_reg(6'd44); chk("t3_rx", rdata0, 32'd0);

        clear_all();
        wr_reg(6'd48, 32'hFFFF_FFF7);
        for (int i = 0; i < 256; i++) cyc(b3, 16'd0, 1'b0, 1'b0, 1'b0, 6'd0, 32'd0);
        rd_reg(6'd3);  chk("t4_cnt3", rdata0, 32'd0);
        chk("t4_irq", 32'(irq0), 32'd1);
        rd_reg(6'd46); chk("t4_carry", rdata0, 32'h8);
        wr_reg(6'd46, 32'h8);
        tick();
        chk("t4_irq_clr", 32'(irq0), 32'd0);

        clear_all();
        for (int i = 0; i < 9; i++) cyc(b10, 16'd0, 1'b0, 1'b0, 1'b0, 6'd0, 32'd0);
        cyc(b10, 16'd0, 1'b0, 1'b1, 1'b0, 6'd10, 32'd0);
        chk("t5_cor_first", rdata1, 32'd9);
        rd_reg(6'd10);
        chk("t5_cor_second", rdata1, 32'd1);
        chk("t5_plain_second", rdata0, 32'd10);

        wr_reg(6'd48, 32'h1234_5678);
        wr_reg(6'd49, 32'h0000_2ABC);
        cyc({44{1'b1}}, 16'd1500, 1'b1, 1'b1, 1'b0, 6'd10, 32'd0);
        chk("t6_preclear_read", rdata0, 32'd10);
        for (int a = 0; a < 48; a++) rd_reg(6'(a));
        rd_reg(6'd48); chk("t6_mask_lo", rdata0, 32'h1234_5678);
        rd_reg(6'd49); chk("t6_mask_hi", rdata0, 32'h0000_2ABC);

        cyc(44'd0, 16'd0, 1'b0, 1'b1, 1'b1, 6'd48, 32'd0);
        rd_reg(6'd48); chk("rdwr_mask_kept", rdata0, 32'h1234_5678);
        rd_reg(6'd60); chk("unmapped", rdata0, 32'd0);

        rd = 1'b1; addr = 6'd48; rst = 1'b1;
        tick();
        chk("rst_mid_read_ack", 32'(ack0), 32'd0);
        rst = 1'b0; idle();
        tick();

        for (int c = 0; c < 3000; c++) begin
            for (int n = 0; n < 44; n++) ri[n] = ($urandom_range(2) == 0);
            inc   = ri;
            len   = 16'($urandom_range(65535));
            clr   = ($urandom_range(199) == 0);
            rd    = ($urandom_range(2) == 0);
            wr    = ($urandom_range(4) == 0);
            addr  = ($urandom_range(1) == 0) ? 6'($urandom_range(63)) : 6'($urandom_range(51, 44));
            wdata = $urandom;
            tick();
        end
        idle();
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
